// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types for the alarm ring sequencer.
// Holds the ring-state encoding, the BCD time payload layout and counter widths.
// The same encodings are used by timegen and the LCD driver.
package alarm_ring_ctrl_pkg;

  localparam int unsigned SNZ_CNT_W  = 3;  // snoozes-used counter width
  localparam int unsigned RING_SEC_W = 8;  // ring-seconds counter width
  localparam int unsigned SNZ_MIN_W  = 4;  // snooze-minutes counter width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  // 16-bit BCD time as produced by the counter and alarm_reg
  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // Current time equals alarm time on every BCD digit
  function automatic logic time_match(input bcd_time_t cur, input bcd_time_t alm);
    return cur == alm;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the alarm clock datapath and the ring sequencer.
//   master : drives ticks, buttons, enable and times; receives sound/snooze status
//   slave  : the ring sequencer side
interface alarm_ring_ctrl_if;
  import alarm_ring_ctrl_pkg::*;

  logic                 one_second;
  logic                 one_minute;
  logic                 alarm_en;
  logic                 snooze_button;
  logic                 stop_button;
  bcd_time_t            cur_time;
  bcd_time_t            alm_time;
  logic                 alarm_sound;
  logic                 snoozing;
  logic [SNZ_CNT_W-1:0] snooze_cnt;

  modport master (
    output one_second, one_minute, alarm_en, snooze_button, stop_button, cur_time, alm_time,
    input  alarm_sound, snoozing, snooze_cnt
  );

  modport slave (
    input  one_second, one_minute, alarm_en, snooze_button, stop_button, cur_time, alm_time,
    output alarm_sound, snoozing, snooze_cnt
  );

endinterface

// File: rtl/alarm_ring_ctrl_tick_counter.sv
// Saturating up-counter with clear and tick enable.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : synchronous clear (wins over tick)
//   tick_i      : count enable pulse
//   reach_c_o   : combinational; high when this tick brings the count to TERM
module alarm_ring_ctrl_tick_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic reach_c_o
);

  localparam logic [WIDTH-1:0] TERM_M1 = WIDTH'(TERM - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, else saturating increment on tick
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // >= keeps the terminal event robust once saturated
  assign reach_c_o = tick_i && (count_q >= TERM_M1);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: detects time match, rings, handles snooze, stop,
// ring timeout with auto-snooze, and lockout until the matching minute passes.
// Ports:
//   clock, reset : system clock, async active-low reset
//   bus (slave)  : ticks, buttons, alarm_en, cur/alm time in; alarm_sound,
//                  snoozing, snooze_cnt out (all registered)
// Build option: define ALARM_RING_BEEP_EN to make alarm_sound toggle on every
// one_second while ringing (starting high); otherwise it is steady high.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic             clock,
  input  logic             reset,
  alarm_ring_ctrl_if.slave bus
);

  logic                 match_q;
  logic                 snz_prev_q;
  logic                 stop_prev_q;
  logic                 snz_edge_q;
  logic                 stop_edge_q;

  state_e               state_q;
  state_e               state_d;
  logic                 sound_q;
  logic                 sound_d;
  logic                 snoozing_q;
  logic                 snoozing_d;
  logic [SNZ_CNT_W-1:0] snz_cnt_q;
  logic [SNZ_CNT_W-1:0] snz_cnt_d;

  logic                 ring_timeout;
  logic                 snz_wake;

  // Registered match and button rising edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_q     <= 1'b0;
      snz_prev_q  <= 1'b0;
      stop_prev_q <= 1'b0;
      snz_edge_q  <= 1'b0;
      stop_edge_q <= 1'b0;
    end else begin
      match_q     <= time_match(bus.cur_time, bus.alm_time);
      snz_prev_q  <= bus.snooze_button;
      stop_prev_q <= bus.stop_button;
      snz_edge_q  <= bus.snooze_button & ~snz_prev_q;
      stop_edge_q <= bus.stop_button & ~stop_prev_q;
    end
  end

  // Seconds rung; held clear outside RINGING so every ring period starts at 0
  alarm_ring_ctrl_tick_counter #(
    .WIDTH (RING_SEC_W),
    .TERM  (RING_SEC)
  ) u_ring_sec (
    .clk       (clock),
    .rst_n     (reset),
    .clr_i     (state_q != RINGING),
    .tick_i    (bus.one_second),
    .reach_c_o (ring_timeout)
  );

  // Minutes snoozed; held clear outside SNOOZE
  alarm_ring_ctrl_tick_counter #(
    .WIDTH (SNZ_MIN_W),
    .TERM  (SNOOZE_MIN)
  ) u_snz_min (
    .clk       (clock),
    .rst_n     (reset),
    .clr_i     (state_q != SNOOZE),
    .tick_i    (bus.one_minute),
    .reach_c_o (snz_wake)
  );

  // Next-state, snooze count and output decode
  always_comb begin
    state_d    = state_q;
    snz_cnt_d  = snz_cnt_q;
    sound_d    = 1'b0;
    snoozing_d = 1'b0;

    if (!bus.alarm_en) begin
      // Disarm overrides every other event
      state_d   = IDLE;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          snz_cnt_d = '0;
          if (match_q) begin
            state_d = RINGING;
          end
        end
        RINGING: begin
          // Stop beats snooze; snooze edge and timeout together are one snooze
          if (stop_edge_q) begin
            state_d = LOCKOUT;
          end else if (snz_edge_q || ring_timeout) begin
            if (snz_cnt_q < SNZ_CNT_W'(MAX_SNOOZE)) begin
              state_d   = SNOOZE;
              snz_cnt_d = snz_cnt_q + SNZ_CNT_W'(1);
            end else begin
              state_d = LOCKOUT;
            end
          end
        end
        SNOOZE: begin
          if (stop_edge_q) begin
            state_d = LOCKOUT;
          end else if (snz_wake) begin
            state_d = RINGING;
          end
        end
        LOCKOUT: begin
          // Wait out the matching minute so it cannot retrigger
          if (!match_q) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          snz_cnt_d = '0;
        end
      endcase
    end

    snoozing_d = (state_d == SNOOZE);

`ifdef ALARM_RING_BEEP_EN
    if (state_d != RINGING) begin
      sound_d = 1'b0;
    end else if (state_q != RINGING) begin
      sound_d = 1'b1;
    end else if (bus.one_second) begin
      sound_d = ~sound_q;
    end else begin
      sound_d = sound_q;
    end
`else
    sound_d = (state_d == RINGING);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sound_q    <= 1'b0;
      snoozing_q <= 1'b0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sound_q    <= sound_d;
      snoozing_q <= snoozing_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign bus.alarm_sound = sound_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_cnt  = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares one entry per clock.
module tb_alarm_ring_ctrl;
  import alarm_ring_ctrl_pkg::*;

  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 60;
  localparam int MAX_SNOOZE = 3;
`ifdef ALARM_RING_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  // Model modes (bench-local encoding)
  localparam int M_OFF = 10, M_RING = 11, M_NAP = 12, M_HOLD = 13;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .SNOOZE_MIN (SNOOZE_MIN),
    .RING_SEC   (RING_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit sound;
    bit snoozing;
    int used;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus levels
  bit          en_v = 1'b0, sb_v = 1'b0, pb_v = 1'b0;
  logic [15:0] cur_v = 16'h0000, alm_v = 16'h0700;

  // Model state
  int mode = M_OFF, secs = 0, mins = 0, used = 0;
  bit phase = 1'b0;
  bit seen_match = 1'b0, seen_snz = 1'b0, seen_stop = 1'b0, last_sb = 1'b0, last_pb = 1'b0;

  function automatic void check(input string name, input int got, input int want, input int at);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, at, got, want);
    end
  endfunction

  task automatic model_reset();
    mode = M_OFF; secs = 0; mins = 0; used = 0; phase = 1'b0;
    seen_match = 1'b0; seen_snz = 1'b0; seen_stop = 1'b0; last_sb = 1'b0; last_pb = 1'b0;
  endtask

  // One clock of the alarm rules; inputs seen through the one-cycle sampling delay
  task automatic model_step(input bit en, input bit sec, input bit mn, input bit sb,
                            input bit pb, input logic [15:0] cur, input logic [15:0] alm);
    exp_t e;
    bit   timeout;
    if (!en) begin
      mode = M_OFF; used = 0;
    end else begin
      case (mode)
        M_OFF: if (seen_match) begin mode = M_RING; secs = 0; used = 0; phase = 1'b1; end
        M_RING: begin
          timeout = sec && (secs + 1 >= RING_SEC);
          if (seen_stop) mode = M_HOLD;
          else if (seen_snz || timeout) begin
            if (used < MAX_SNOOZE) begin mode = M_NAP; used++; mins = 0; end
            else mode = M_HOLD;
          end else if (sec) begin
            if (secs < 255) secs++;
            phase = !phase;
          end
        end
        M_NAP: begin
          if (seen_stop) mode = M_HOLD;
          else if (mn) begin
            mins++;
            if (mins >= SNOOZE_MIN) begin mode = M_RING; secs = 0; phase = 1'b1; end
          end
        end
        default: if (!seen_match) begin mode = M_OFF; used = 0; end
      endcase
    end
    seen_match = (cur == alm);
    seen_snz   = sb && !last_sb;
    seen_stop  = pb && !last_pb;
    last_sb    = sb;
    last_pb    = pb;
    e.sound    = (mode == M_RING) && (BEEP ? phase : 1'b1);
    e.snoozing = (mode == M_NAP);
    e.used     = used;
    e.cyc      = cyc;
    exp_q.push_back(e);
  endtask

  // Drive one cycle from the current negedge, then advance to the next negedge
  task automatic tick(input bit sec, input bit mn);
    bus.alarm_en      = en_v;
    bus.one_second    = sec;
    bus.one_minute    = mn;
    bus.snooze_button = sb_v;
    bus.stop_button   = pb_v;
    bus.cur_time      = bcd_time_t'(cur_v);
    bus.alm_time      = bcd_time_t'(alm_v);
    model_step(en_v, sec, mn, sb_v, pb_v, cur_v, alm_v);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic press(input bit s, input bit p);
    sb_v = s; pb_v = p;
    tick(1'b0, 1'b0);
    sb_v = 1'b0; pb_v = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    check("async_rst_sound", int'(bus.alarm_sound), 0, cyc);
    check("async_rst_snoozing", int'(bus.snoozing), 0, cyc);
    check("async_rst_cnt", int'(bus.snooze_cnt), 0, cyc);
    model_reset();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: one expected entry per clock while out of reset
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("alarm_sound", int'(bus.alarm_sound), int'(e.sound), e.cyc);
      check("snoozing", int'(bus.snoozing), int'(e.snoozing), e.cyc);
      check("snooze_cnt", int'(bus.snooze_cnt), e.used, e.cyc);
    end
  end

  initial begin
    bus.alarm_en = 1'b0; bus.one_second = 1'b0; bus.one_minute = 1'b0;
    bus.snooze_button = 1'b0; bus.stop_button = 1'b0;
    bus.cur_time = '0; bus.alm_time = '0;
    #1;
    check("reset_sound", int'(bus.alarm_sound), 0, 0);
    check("reset_snoozing", int'(bus.snoozing), 0, 0);
    check("reset_cnt", int'(bus.snooze_cnt), 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Match detection, armed and disarmed
    en_v = 1'b1; cur_v = 16'h0659; idle(3);
    cur_v = 16'h0700; idle(4);
    press(1'b0, 1'b1); cur_v = 16'h0659; idle(3);
    en_v = 1'b0; cur_v = 16'h0700; idle(5);
    cur_v = 16'h0659; idle(2); en_v = 1'b1; idle(2);

    // Manual snooze then wake after SNOOZE_MIN minutes
    cur_v = 16'h0700; idle(3);
    press(1'b1, 1'b0); idle(2);
    for (int i = 0; i < SNOOZE_MIN; i++) begin tick(1'b0, 1'b1); tick(1'b1, 1'b0); end
    idle(2); press(1'b0, 1'b1); cur_v = 16'h0659; idle(3);

    // Ring timeouts: MAX_SNOOZE auto-snoozes, then lockout
    cur_v = 16'h0700; idle(3);
    for (int k = 0; k <= MAX_SNOOZE; k++) begin
      for (int s = 0; s < RING_SEC; s++) tick(1'b1, 1'b0);
      if (k < MAX_SNOOZE) for (int m = 0; m < SNOOZE_MIN; m++) tick(1'b1, 1'b1);
    end
    idle(3); cur_v = 16'h0659; idle(3);

    // Stop while still matching: no retrigger until the minute changes
    cur_v = 16'h0700; idle(3); press(1'b0, 1'b1); idle(5);
    cur_v = 16'h0701; idle(2); cur_v = 16'h0700; idle(4);

    // Simultaneous snooze and stop; disarm mid-ring
    press(1'b1, 1'b1); idle(2); cur_v = 16'h0659; idle(3);
    cur_v = 16'h0700; idle(3); en_v = 1'b0; idle(2); en_v = 1'b1; idle(3);

    // Held snooze button repeats nothing; then reset mid-snooze
    sb_v = 1'b1; idle(4);
    for (int m = 0; m < SNOOZE_MIN; m++) tick(1'b0, 1'b1);
    idle(3); sb_v = 1'b0; idle(1); press(1'b1, 1'b0); idle(2);
    async_reset_check();
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 20000; n++) begin
      logic [15:0] choices [3];
      choices[0] = 16'h0659; choices[1] = 16'h0700; choices[2] = 16'h0701;
      if ($urandom_range(0, 79) == 0) cur_v = choices[$urandom_range(0, 2)];
      if ($urandom_range(0, 999) == 0) cur_v = 16'($urandom);
      if (en_v) begin if ($urandom_range(0, 399) == 0) en_v = 1'b0; end
      else if ($urandom_range(0, 7) == 0) en_v = 1'b1;
      if (sb_v) begin if ($urandom_range(0, 3) == 0) sb_v = 1'b0; end
      else if ($urandom_range(0, 59) == 0) sb_v = 1'b1;
      if (pb_v) begin if ($urandom_range(0, 2) == 0) pb_v = 1'b0; end
      else if ($urandom_range(0, 149) == 0) pb_v = 1'b1;
      if ($urandom_range(0, 4999) == 0) async_reset_check();
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 14) == 0));
    end

    idle(2);
    @(posedge clock); #2;
    check("scoreboard_drained", exp_q.size(), 0, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
